// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and STATUS layout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;
  localparam int unsigned STAT_CNT_LSB   = 8;

  // STATUS word as seen by a load; field order matches the bit positions above.
  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push while full is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// UART 8N1 transmitter snooping the core's store bus; TXDATA queues a byte,
// STATUS reports FIFO/line state and clears the sticky overflow flag.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  be,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  tx_state_e   state;
  logic [BW-1:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        overflow;

  logic [2:0]  off;
  logic        wr_tx;
  logic        wr_st;
  logic        baud_last;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [AW:0] fifo_count;
  status_t     status;
  logic        unused_bits;

  // Size and upper data bits play no part in decode or payload.
  assign unused_bits = ^{be, WriteData[31:8]};

  assign off       = DataAdr[2:0];
  assign sel       = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign wr_tx     = MemWrite & sel & (off == TXDATA_OFF);
  assign wr_st     = MemWrite & sel & (off == STATUS_OFF);
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign fifo_pop  = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_last));
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .wdata (WriteData[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Combinational read path so the single-cycle core can load in the same cycle.
  always_comb begin
    status          = '0;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.busy     = busy;
    status.overflow = overflow;
    status.count    = 4'(fifo_count);
    rdata           = '0;
    if (sel && (off == STATUS_OFF)) rdata = status;
  end

  // Sticky overflow: a dropped byte outranks a clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_tx && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (wr_st && WriteData[STAT_OVF_BIT]) begin
      overflow <= 1'b0;
    end
  end

  // TX framer; tx is registered so reset forces the line high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift <= fifo_rdata;
            baud  <= '0;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= ST_DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (!fifo_empty) begin
              shift <= fifo_rdata;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned CPB  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [1:0]  be;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic cap [0:399];

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .be        (be),
    .sel       (sel),
    .rdata     (rdata),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected line level j cycles into a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    int s;
    s = j / CPB;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return b[s-1];
  endfunction

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; be = 2'b10;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    DataAdr = BASE + 32'd4;
    #1;
    n_assert++; if (sel !== 1'b1) begin n_fail++; $display("FAIL reset_sel got %b want 1", sel); end
    n_assert++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status got %h want 00000002", rdata); end
    n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'h0000_0055;
    @(posedge clk); @(negedge clk);
    MemWrite = 1'b0; DataAdr = BASE + 32'd4;
    #1;
    n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_prestart_tx got %b want 1", tx); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_after_push got %b want 1", busy); end
    n_assert++; if (rdata !== 32'h0000_0104) begin n_fail++; $display("FAIL single_status got %h want 00000104", rdata); end
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); @(negedge clk);
      n_assert++;
      if (tx !== exp_bit(8'h55, j)) begin
        n_fail++; $display("FAIL single_tx cycle %0d got %b want %b", j, tx, exp_bit(8'h55, j));
      end
      if (j == 39) begin
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_stop got %b want 1", busy); end
      end
    end
    @(posedge clk); @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_idle got %b want 1", tx); end
  endtask

  task automatic test_back_to_back();
    int errs;
    for (int k = 0; k <= 361; k++) begin
      if (k < 10) begin
        MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'(k);
      end else if (k == 11) begin
        MemWrite = 1'b1; DataAdr = BASE + 32'd4; WriteData = 32'h0;
      end else if (k == 13) begin
        MemWrite = 1'b1; DataAdr = BASE + 32'd4; WriteData = 32'h8;
      end else begin
        MemWrite = 1'b0; DataAdr = BASE + 32'd4;
      end
      @(posedge clk); @(negedge clk);
      cap[k] = tx;
      if (k == 9) begin
        MemWrite = 1'b0; DataAdr = BASE + 32'd4; #1;
        n_assert++; if (rdata !== 32'h0000_080D) begin n_fail++; $display("FAIL burst_status got %h want 0000080d", rdata); end
      end
      if (k == 12) begin
        #1;
        n_assert++; if (rdata !== 32'h0000_080D) begin n_fail++; $display("FAIL clear_zero_keeps_ovf got %h want 0000080d", rdata); end
      end
      if (k == 14) begin
        #1;
        n_assert++; if (rdata !== 32'h0000_0805) begin n_fail++; $display("FAIL clear_ovf got %h want 00000805", rdata); end
      end
      if (k == 360) begin
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy_last_stop got %b want 1", busy); end
      end
      if (k == 361) begin
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end got %b want 0", busy); end
        n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL burst_tx_idle got %b want 1", tx); end
      end
    end
    n_assert++; if (cap[0] !== 1'b1) begin n_fail++; $display("FAIL burst_prestart_tx got %b want 1", cap[0]); end
    for (int f = 0; f < 9; f++) begin
      errs = 0;
      for (int j = 0; j < 40; j++) begin
        if (cap[1 + 40*f + j] !== exp_bit(8'(f), j)) errs++;
      end
      n_assert++;
      if (errs !== 0) begin n_fail++; $display("FAIL burst_frame %0d bad cycles got %0d want 0", f, errs); end
    end
  endtask

  task automatic test_reserved();
    int errs;
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = BASE + 32'd6; WriteData = 32'h77; #1;
    n_assert++; if (sel !== 1'b1) begin n_fail++; $display("FAIL reserved_sel got %b want 1", sel); end
    n_assert++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reserved_rdata got %h want 00000000", rdata); end
    @(posedge clk); @(negedge clk);
    DataAdr = 32'h1000_0010; WriteData = 32'h78; #1;
    n_assert++; if (sel !== 1'b0) begin n_fail++; $display("FAIL outside_sel got %b want 0", sel); end
    n_assert++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL outside_rdata got %h want 00000000", rdata); end
    @(posedge clk); @(negedge clk);
    DataAdr = BASE + 32'd8; WriteData = 32'h79;
    @(posedge clk); @(negedge clk);
    MemWrite = 1'b0; DataAdr = BASE + 32'd4; #1;
    n_assert++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL reserved_status got %h want 00000002", rdata); end
    errs = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    n_assert++; if (errs !== 0) begin n_fail++; $display("FAIL reserved_tx_low cycles got %0d want 0", errs); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int errs;
    for (int k = 0; k <= 18; k++) begin
      if (k < 4) begin
        MemWrite = 1'b1; DataAdr = BASE; WriteData = 32'h0;
      end else begin
        MemWrite = 1'b0; DataAdr = BASE + 32'd4;
      end
      @(posedge clk); @(negedge clk);
    end
    #1;
    n_assert++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_bit3_tx got %b want 0", tx); end
    n_assert++; if (rdata !== 32'h0000_0304) begin n_fail++; $display("FAIL midframe_status got %h want 00000304", rdata); end
    #2 reset = 1'b0;
    #1;
    n_assert++; if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx got %b want 1", tx); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    n_assert++; if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL post_reset_status got %h want 00000002", rdata); end
    errs = 0;
    for (int j = 0; j < 50; j++) begin
      @(posedge clk); @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    n_assert++; if (errs !== 0) begin n_fail++; $display("FAIL post_reset_activity cycles got %0d want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reserved();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle core's data-memory bus, in parallel with the data memory. Snoops the store interface (`MemWrite`, `DataAdr`, `WriteData`) for its address window and queues bytes in a small FIFO. Serialises each byte as 8N1 on `tx`. Returns a status word for loads from its window through a read-select/read-data pair that the top-level read mux consumes.

## Interface
- `BASE_ADDR`, 32'h1000_0000, word-aligned base of the 8-byte window.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `MemWrite`  in  1  store strobe from the core.
- `DataAdr`  in  32  load/store address from the core.
- `WriteData`  in  32  store data from the core.
- `be`  in  2  store size (funct3[1:0]); ignored for decode, any size accepted.
- `sel`  out  1  `DataAdr` is inside the window (combinational).
- `rdata`  out  32  read data for the window (combinational).
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- Decode uses `DataAdr[31:3] == BASE_ADDR[31:3]`. Offset 0 is TXDATA; offset 4 is STATUS; other offsets are reserved, read 0, and ignore writes.
- Store to TXDATA pushes `WriteData[7:0]` in the same edge.
  - If the FIFO is full and no pop happens that edge, the byte is dropped and sticky `overflow` is set.
- Store to STATUS with `WriteData[3]=1` clears `overflow`; other bits are ignored.
- STATUS read value: bit0 `full`, bit1 `empty`, bit2 `busy`, bit3 `overflow`, bits[11:8] FIFO count. All other bits are 0. TXDATA reads 0.
- TX state machine has four states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then pop and go to START if the FIFO is non-empty, else go to IDLE.
- Counters:
  - Baud counter is 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Bit index is 3 bits.
  - FIFO pointers are log2(`FIFO_DEPTH`) bits plus one wrap bit. Full is pointers equal except the wrap bit.
- Simultaneous push and pop with the FIFO full: both take effect, count is unchanged, no overflow.
- Simultaneous push and pop with the FIFO empty: not possible, because pop requires non-empty before the edge.
- Simultaneous overflow set and clear: set wins.
- Reset values: `tx`=1, `busy`=0, state IDLE, FIFO empty, `overflow`=0, counters 0.
- Reset asserted mid-frame aborts the frame immediately (`tx`=1 asynchronously) and discards all queued bytes.

## Timing
- A store sampled at edge E0 is visible in STATUS after E0.
- With the FSM in IDLE, the pop happens at E1 and `tx` falls after E1. That is one cycle of write-to-start latency.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames have no idle cycle: the next start bit follows the stop bit directly.
- `busy` is registered-equivalent: high from the edge after the push until the end of the final STOP period.
- `sel` and `rdata` are combinational from `DataAdr` and current state, so the single-cycle core can use them in the same cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - offsets `TXDATA_OFF=0` and `STATUS_OFF=4`;
  - STATUS bit positions.
- One sub-module, `sync_fifo`: parameterised width/depth, with push/pop/full/empty/count, async active-low reset.
- Top body holds the decode, the overflow flag and the TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
1. Reset released, load from BASE+4 → `sel`=1, `rdata`=32'h0000_0002, `tx`=1, `busy`=0.
2. Single store 0x55 to BASE → `tx` low 1 cycle after the store edge for 4 cycles. Then the data bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles. `busy` drops 40 cycles after the start bit begins.
3. Ten consecutive store cycles to BASE (bytes 0x00–0x09) → byte 0x00 transmits, 0x01–0x08 are queued, 0x09 is dropped. STATUS = 32'h0000_080D. All transmitted frames are back-to-back with no idle cycle.
4. After scenario 3, store 0x8 to BASE+4 → overflow bit clears, bits 0/2/11:8 are unchanged. Storing 0x0 leaves overflow set.
5. Store to BASE+8 and to 0x1000_0010 → `sel`=0 for the latter. FIFO count is unchanged and `tx` stays high.
6. Reset asserted during bit 3 of a frame with 3 bytes queued → `tx`=1 without waiting for a clock edge. After release, STATUS = 32'h0000_0002 and no further frames are sent.
